regfile_mp: RTL and testbench

Parametrised multi-port integer register file with per-register scoreboard, the successor of the single-write general-purpose register file in the NPC core. It provides NRD combinational read ports and NWR synchronous write ports, with optional same-cycle write-to-read bypass. A busy-bit scoreboard lets the pipelined decode stage detect RAW hazards on registers with an in-flight producer. Register 0 is hard-wired to zero.

---
 rtl/regfile_mp.sv | 60 ++++++
 tb/tb_regfile_mp.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass and busy-bit scoreboard, x0 hard-wired to zero
module regfile_mp #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NRD-1:0]     rs_en,
  input  logic [NRD*AW-1:0]  rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]     rs_busy,
  input  logic [NWR-1:0]     wr_en,
  input  logic [NWR*AW-1:0]  wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NWR-1:0]     wr_clr,
  input  logic               iss_en,
  input  logic [AW-1:0]      iss_rd,
  output logic [NREG-1:0]    sb_busy,
  input  logic [AW-1:0]      dbg_addr,
  output logic [XLEN-1:0]    dbg_data
);
  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy, busy_nxt;
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] != '0) rf[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
    end
  end
  // issue is applied after clears so a new producer supersedes the retiring one
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && wr_clr[j]) busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
    if (iss_en) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk) busy <= !reset ? '0 : busy_nxt;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic [XLEN-1:0] d;
    assign a = rs_addr[i*AW +: AW];
    always_comb begin
      d = rf[a];
      if (BYPASS != 0)
        for (int j = 0; j < NWR; j++)
          if (wr_en[j] && wr_addr[j*AW +: AW] == a) d = wr_data[j*XLEN +: XLEN];
    end
    assign rs_data[i*XLEN +: XLEN] = (rs_en[i] && a != '0) ? d : '0;
    assign rs_busy[i] = rs_en[i] & busy[a];
  end
  assign sb_busy = busy;
  assign dbg_data = rf[dbg_addr];
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table plus randomized reference-model run, BYPASS=1 and BYPASS=0 side by side
module tb_regfile_mp;
  localparam int XLEN = 64, NREG = 32, NRD = 2, NWR = 2, AW = 5;
  typedef struct packed {
    logic [1:0][63:0] d1;
    logic [1:0][63:0] d0;
    logic [1:0] rb;
    logic [31:0] sb;
    logic [63:0] dbg;
  } exp_t;
  typedef struct packed {
    logic rn;
    logic [1:0] we;
    logic [4:0] wa0, wa1;
    logic [63:0] wd0, wd1;
    logic [1:0] wc;
    logic ie;
    logic [4:0] ir;
    logic [1:0] re;
    logic [4:0] ra0, ra1, da;
    exp_t e;
  } vec_t;
  logic clk = 1'b0, reset = 1'b0;
  logic [NRD-1:0] rs_en = '0;
  logic [NRD*AW-1:0] rs_addr = '0;
  logic [NRD*XLEN-1:0] rs_data1, rs_data0;
  logic [NRD-1:0] rs_busy1, rs_busy0;
  logic [NWR-1:0] wr_en = '0, wr_clr = '0;
  logic [NWR*AW-1:0] wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic iss_en = 1'b0;
  logic [AW-1:0] iss_rd = '0, dbg_addr = '0;
  logic [NREG-1:0] sb1, sb0;
  logic [XLEN-1:0] dbg1, dbg0;
  logic [63:0] m_rf [NREG];
  logic [NREG-1:0] m_busy;
  exp_t q[$];
  vec_t tbl [19];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .rs_en(rs_en), .rs_addr(rs_addr), .rs_data(rs_data1), .rs_busy(rs_busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr), .iss_en(iss_en), .iss_rd(iss_rd),
    .sb_busy(sb1), .dbg_addr(dbg_addr), .dbg_data(dbg1));
  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .rs_en(rs_en), .rs_addr(rs_addr), .rs_data(rs_data0), .rs_busy(rs_busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr), .iss_en(iss_en), .iss_rd(iss_rd),
    .sb_busy(sb0), .dbg_addr(dbg_addr), .dbg_data(dbg0));
  function automatic vec_t mk(logic rn, logic [1:0] we, logic [4:0] wa0, logic [4:0] wa1, logic [63:0] wd0,
      logic [63:0] wd1, logic [1:0] wc, logic ie, logic [4:0] ir, logic [1:0] re, logic [4:0] ra0,
      logic [4:0] ra1, logic [4:0] da, logic [63:0] x0, logic [63:0] x1, logic [63:0] y0, logic [63:0] y1,
      logic [1:0] rb, logic [31:0] sb, logic [63:0] dbg);
    vec_t v;
    v.rn = rn; v.we = we; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1; v.wc = wc;
    v.ie = ie; v.ir = ir; v.re = re; v.ra0 = ra0; v.ra1 = ra1; v.da = da;
    v.e.d1[0] = x0; v.e.d1[1] = x1; v.e.d0[0] = y0; v.e.d0[1] = y1;
    v.e.rb = rb; v.e.sb = sb; v.e.dbg = dbg;
    return v;
  endfunction
  function automatic exp_t model_exp();
    exp_t e;
    for (int i = 0; i < NRD; i++) begin
      logic [4:0] a;
      logic [63:0] v;
      logic live;
      a = rs_addr[i*AW +: AW];
      live = rs_en[i] && a != 5'd0;
      v = m_rf[a];
      e.d0[i] = live ? v : 64'd0;
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*XLEN +: XLEN];
      e.d1[i] = live ? v : 64'd0;
      e.rb[i] = live && m_busy[a];
    end
    e.sb = m_busy;
    e.dbg = m_rf[dbg_addr];
    return e;
  endfunction
  task automatic model_update();
    if (!reset) begin
      for (int r = 0; r < NREG; r++) m_rf[r] = 64'd0;
      m_busy = '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        logic set, clr;
        set = iss_en && iss_rd == 5'(r);
        clr = 1'b0;
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] == 5'(r)) begin
            m_rf[r] = wr_data[j*XLEN +: XLEN];
            if (wr_clr[j]) clr = 1'b1;
          end
        end
        m_busy[r] = set ? 1'b1 : clr ? 1'b0 : m_busy[r];
      end
    end
  endtask
  task automatic chk(string n, logic [63:0] act, logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask
  task automatic step(exp_t e);
    exp_t g;
    q.push_back(e);
    #1;
    g = q.pop_front();
    chk("rd0_byp", rs_data1[63:0], g.d1[0]);
    chk("rd1_byp", rs_data1[127:64], g.d1[1]);
    chk("rd0_nob", rs_data0[63:0], g.d0[0]);
    chk("rd1_nob", rs_data0[127:64], g.d0[1]);
    chk("rs_busy_byp", 64'(rs_busy1), 64'(g.rb));
    chk("rs_busy_nob", 64'(rs_busy0), 64'(g.rb));
    chk("sb_busy_byp", 64'(sb1), 64'(g.sb));
    chk("sb_busy_nob", 64'(sb0), 64'(g.sb));
    chk("dbg_byp", dbg1, g.dbg);
    chk("dbg_nob", dbg0, g.dbg);
    tick();
  endtask
  task automatic drive(vec_t v);
    reset = v.rn; wr_en = v.we; wr_addr = {v.wa1, v.wa0}; wr_data = {v.wd1, v.wd0}; wr_clr = v.wc;
    iss_en = v.ie; iss_rd = v.ir; rs_en = v.re; rs_addr = {v.ra1, v.ra0}; dbg_addr = v.da;
  endtask
  function automatic logic [4:0] raddr();
    return $urandom_range(1) != 0 ? 5'($urandom_range(3)) : 5'($urandom_range(31));
  endfunction
  task automatic rand_drive();
    reset = $urandom_range(199) != 0;
    wr_en = 2'($urandom);
    wr_clr = 2'($urandom);
    wr_addr = {raddr(), raddr()};
    wr_data = {$urandom, $urandom, $urandom, $urandom};
    iss_en = $urandom_range(3) == 0;
    iss_rd = raddr();
    rs_en = 2'($urandom);
    rs_addr = {raddr(), raddr()};
    dbg_addr = raddr();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0]  = mk(1, 2'b01, 5, 0, 'hDEAD, 0, 0, 0, 0, 2'b11, 5, 0, 5, 'hDEAD, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 2'b10, 0, 9, 0, 1, 0, 1, 6, 2'b01, 5, 0, 5, 'hDEAD, 0, 'hDEAD, 0, 0, 0, 'hDEAD);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 5, 9, 5, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 2'b01, 0, 0, '1, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 2'b01, 7, 0, 'h1234, 0, 0, 0, 0, 2'b11, 7, 7, 7, 'h1234, 'h1234, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 7, 7, 7, 'h1234, 'h1234, 'h1234, 'h1234, 0, 0, 'h1234);
    tbl[7]  = mk(1, 2'b11, 3, 3, 'hAA, 'hBB, 0, 0, 0, 2'b11, 3, 3, 3, 'hBB, 'hBB, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3, 3, 3, 'hBB, 'hBB, 'hBB, 'hBB, 0, 0, 'hBB);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 10, 2'b11, 10, 10, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 2'b01, 10, 0, 'h55, 0, 0, 0, 0, 2'b11, 10, 10, 10, 'h55, 'h55, 0, 0, 2'b11, 'h400, 0);
    tbl[11] = mk(1, 2'b10, 0, 10, 0, 'h66, 2'b10, 0, 0, 2'b11, 10, 10, 10, 'h66, 'h66, 'h55, 'h55, 2'b11, 'h400, 'h55);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 10, 10, 10, 'h66, 0, 'h66, 0, 0, 0, 'h66);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 1, 10, 2'b11, 10, 10, 10, 'h66, 'h66, 'h66, 'h66, 0, 0, 'h66);
    tbl[14] = mk(1, 2'b01, 10, 0, 'h77, 0, 2'b01, 1, 10, 2'b11, 10, 10, 10, 'h77, 'h77, 'h66, 'h66, 2'b11, 'h400, 'h66);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 10, 10, 10, 'h77, 'h77, 'h77, 'h77, 2'b11, 'h400, 'h77);
    tbl[16] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 0, 10, 10, 0, 'h77, 0, 'h77, 2'b10, 'h400, 'h77);
    tbl[17] = mk(1, 0, 10, 0, 0, 0, 2'b01, 0, 0, 2'b01, 0, 10, 10, 0, 0, 0, 0, 0, 'h400, 'h77);
    tbl[18] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 10, 10, 10, 0, 0, 0, 0, 0, 'h400, 'h77);
    @(negedge clk);
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 19; k++) begin
      drive(tbl[k]);
      step(tbl[k].e);
    end
    // x10 is still busy here; reset must beat a same-cycle issue and write
    drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0));
    step(model_exp());
    drive(mk(0, 2'b01, 7, 0, 9, 0, 0, 1, 14, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0));
    step(model_exp());
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 7, 12, 7, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("mid_reset_sb", 64'(sb1), 64'd0);
    chk("mid_reset_dbg", dbg1, 64'd0);
    chk("mid_reset_rd", rs_data0[63:0], 64'd0);
    chk("mid_reset_busy", 64'(rs_busy1), 64'd0);
    tick();
    for (int n = 0; n < 10000; n++) begin
      rand_drive();
      step(model_exp());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
